// File: rtl/alu_seq_pkg.sv
// Shared opcodes, flag bit positions and FSM encoding for the sequential flag ALU.
package alu_seq_pkg;

    localparam logic [4:0] OP_DEC = 5'd0;
    localparam logic [4:0] OP_AND = 5'd1;
    localparam logic [4:0] OP_OR  = 5'd2;
    localparam logic [4:0] OP_NOT = 5'd3;
    localparam logic [4:0] OP_XOR = 5'd4;
    localparam logic [4:0] OP_ADD = 5'd5;
    localparam logic [4:0] OP_SUB = 5'd6;
    localparam logic [4:0] OP_INC = 5'd7;
    localparam logic [4:0] OP_SHL = 5'd8;
    localparam logic [4:0] OP_SHR = 5'd9;
    localparam logic [4:0] OP_SAR = 5'd10;
    localparam logic [4:0] OP_ROL = 5'd11;
    localparam logic [4:0] OP_ROR = 5'd12;
    localparam logic [4:0] OP_MUL = 5'd13;
    localparam logic [4:0] OP_DIV = 5'd14;
    localparam logic [4:0] OP_MOD = 5'd15;

    localparam int FLG_C = 0;
    localparam int FLG_Z = 1;
    localparam int FLG_N = 2;
    localparam int FLG_V = 3;
    localparam int FLG_P = 4;
    localparam int FLG_E = 5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/alu_iter_div.sv
// Restoring shift-subtract unsigned divider, one quotient bit per cycle.
// Only instantiated by alu_seq_flags when ALU_DIV_EN is defined.
module alu_iter_div #(
    parameter int WIDTH = 8
) (
    input  logic             iClk,
    input  logic             iRst_n,
    input  logic             iStart,
    input  logic [WIDTH-1:0] iA,
    input  logic [WIDTH-1:0] iB,
    output logic             oBusy,
    output logic             oDone,
    output logic [WIDTH-1:0] oQuo,
    output logic [WIDTH-1:0] oRem
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic             busy_q, busy_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] b_q, b_d;

    logic [WIDTH:0]   trial;
    logic             ge;
    logic [WIDTH-1:0] step_r;
    logic [WIDTH-1:0] step_q;

    // Partial remainder stays below the divisor, so trial-b always fits WIDTH bits.
    always_comb begin
        trial  = {r_q, q_q[WIDTH-1]};
        ge     = (trial >= {1'b0, b_q});
        step_r = ge ? (trial[WIDTH-1:0] - b_q) : trial[WIDTH-1:0];
        step_q = {q_q[WIDTH-2:0], ge};
    end

    always_comb begin
        busy_d = busy_q;
        cnt_d  = cnt_q;
        r_d    = r_q;
        q_d    = q_q;
        b_d    = b_q;
        if (iStart) begin
            busy_d = 1'b1;
            cnt_d  = '0;
            r_d    = '0;
            q_d    = iA;
            b_d    = iB;
        end else if (busy_q) begin
            r_d   = step_r;
            q_d   = step_q;
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
                busy_d = 1'b0;
            end
        end
    end

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
            r_q    <= '0;
            q_q    <= '0;
            b_q    <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
            r_q    <= r_d;
            q_q    <= q_d;
            b_q    <= b_d;
        end
    end

    // Final quotient/remainder are the step values during the last iteration cycle.
    assign oBusy = busy_q;
    assign oDone = busy_q && (cnt_q == CNT_W'(WIDTH - 1));
    assign oQuo  = step_q;
    assign oRem  = step_r;

endmodule

// File: rtl/alu_seq_flags.sv
// Handshaked WIDTH-bit ALU with registered result/flags {E,P,V,N,Z,C}.
// Define ALU_DIV_EN to enable the iterative DIV/MOD unit; otherwise opcodes 14/15 are illegal.
module alu_seq_flags
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             iClk,
    input  logic             iRst_n,
    input  logic             iValid,
    output logic             oReady,
    input  logic [4:0]       iOp,
    input  logic [WIDTH-1:0] iA,
    input  logic [WIDTH-1:0] iB,
    output logic             oValid,
    output logic [WIDTH-1:0] oResp,
    output logic [5:0]       oFlags
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t             state_q, state_d;
    logic               pend_q, pend_d;
    logic [4:0]         op_q, op_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   resp_q, resp_d;
    logic [5:0]         flags_q, flags_d;

    logic               accept;
    logic               is_iter;
    logic [WIDTH-1:0]   alu_res;
    logic               alu_c, alu_v, alu_e;
    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] rot;
    logic [SHW-1:0]     amt, rot_amt;
    logic signed [WIDTH-1:0] a_sgn;
    logic [2*WIDTH-1:0] mul_next;

    function automatic logic [5:0] mk_flags(input logic [WIDTH-1:0] r, input logic e,
                                            input logic v, input logic c);
        logic [5:0] f;
        f        = '0;
        f[FLG_C] = c;
        f[FLG_Z] = (r == '0);
        f[FLG_N] = r[WIDTH-1];
        f[FLG_V] = v;
        f[FLG_P] = ^r;
        f[FLG_E] = e;
        return f;
    endfunction

    assign oReady = ((state_q == ST_IDLE) && !pend_q) || (state_q == ST_DONE);
    assign oValid = (state_q == ST_DONE);
    assign oResp  = resp_q;
    assign oFlags = flags_q;
    assign accept = iValid && oReady;
    assign a_sgn  = a_q;

    // Single-cycle datapath on the latched request; iterative ops only raise is_iter.
    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        alu_e   = 1'b0;
        is_iter = 1'b0;
        sum     = '0;
        rot     = '0;
        amt     = b_q[SHW-1:0];
        rot_amt = SHW'(int'(amt) % WIDTH);
        case (op_q)
            OP_DEC: begin
                sum     = {1'b0, a_q} - (WIDTH+1)'(1);
                alu_res = sum[WIDTH-1:0];
                alu_c   = sum[WIDTH];
                alu_v   = a_q[WIDTH-1] & ~alu_res[WIDTH-1];
            end
            OP_AND: alu_res = a_q & b_q;
            OP_OR:  alu_res = a_q | b_q;
            OP_NOT: alu_res = ~a_q;
            OP_XOR: alu_res = a_q ^ b_q;
            OP_ADD: begin
                sum     = {1'b0, a_q} + {1'b0, b_q};
                alu_res = sum[WIDTH-1:0];
                alu_c   = sum[WIDTH];
                alu_v   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (alu_res[WIDTH-1] != a_q[WIDTH-1]);
            end
            OP_SUB: begin
                sum     = {1'b0, a_q} - {1'b0, b_q};
                alu_res = sum[WIDTH-1:0];
                alu_c   = sum[WIDTH];
                alu_v   = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (alu_res[WIDTH-1] != a_q[WIDTH-1]);
            end
            OP_INC: begin
                sum     = {1'b0, a_q} + (WIDTH+1)'(1);
                alu_res = sum[WIDTH-1:0];
                alu_c   = sum[WIDTH];
                alu_v   = ~a_q[WIDTH-1] & alu_res[WIDTH-1];
            end
            OP_SHL: {alu_c, alu_res} = {1'b0, a_q} << amt;
            OP_SHR: {alu_res, alu_c} = {a_q, 1'b0} >> amt;
            OP_SAR: alu_res = a_sgn >>> amt;
            OP_ROL: begin
                rot     = {a_q, a_q} << rot_amt;
                alu_res = rot[2*WIDTH-1:WIDTH];
            end
            OP_ROR: begin
                rot     = {a_q, a_q} >> rot_amt;
                alu_res = rot[WIDTH-1:0];
            end
            OP_MUL: is_iter = 1'b1;
`ifdef ALU_DIV_EN
            OP_DIV: begin
                if (b_q == '0) begin
                    alu_res = '1;
                    alu_e   = 1'b1;
                end else begin
                    is_iter = 1'b1;
                end
            end
            OP_MOD: begin
                if (b_q == '0) begin
                    alu_res = a_q;
                    alu_e   = 1'b1;
                end else begin
                    is_iter = 1'b1;
                end
            end
`endif
            default: alu_e = 1'b1;
        endcase
    end

    assign mul_next = acc_q + (b_q[cnt_q] ? ({{WIDTH{1'b0}}, a_q} << cnt_q) : '0);

`ifdef ALU_DIV_EN
    logic             div_start, div_busy, div_done;
    logic [WIDTH-1:0] div_quo, div_rem, div_res;

    assign div_start = (state_q == ST_IDLE) && pend_q && is_iter && (op_q != OP_MUL);
    assign div_res   = (op_q == OP_DIV) ? div_quo : div_rem;

    alu_iter_div #(.WIDTH(WIDTH)) u_div (
        .iClk   (iClk),
        .iRst_n (iRst_n),
        .iStart (div_start),
        .iA     (a_q),
        .iB     (b_q),
        .oBusy  (div_busy),
        .oDone  (div_done),
        .oQuo   (div_quo),
        .oRem   (div_rem)
    );
`endif

    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        resp_d  = resp_q;
        flags_d = flags_q;
        case (state_q)
            ST_IDLE: begin
                if (pend_q) begin
                    pend_d = 1'b0;
                    if (is_iter) begin
                        state_d = ST_BUSY;
                        cnt_d   = '0;
                        acc_d   = '0;
                    end else begin
                        state_d = ST_DONE;
                        resp_d  = alu_res;
                        flags_d = mk_flags(alu_res, alu_e, alu_v, alu_c);
                    end
                end
            end
            ST_BUSY: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (op_q == OP_MUL) begin
                    acc_d = mul_next;
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        state_d = ST_DONE;
                        resp_d  = mul_next[WIDTH-1:0];
                        flags_d = mk_flags(mul_next[WIDTH-1:0], 1'b0,
                                           |mul_next[2*WIDTH-1:WIDTH], 1'b0);
                    end
                end
`ifdef ALU_DIV_EN
                // An idle divider here also ends BUSY so the FSM can never stall.
                else if (div_done || !div_busy) begin
                    state_d = ST_DONE;
                    resp_d  = div_res;
                    flags_d = mk_flags(div_res, 1'b0, 1'b0, 1'b0);
                end
`endif
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        // A request taken in DONE goes straight back through the IDLE decode cycle.
        if (accept) begin
            pend_d = 1'b1;
            op_d   = iOp;
            a_d    = iA;
            b_d    = iB;
        end
    end

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            state_q <= ST_IDLE;
            pend_q  <= 1'b0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            cnt_q   <= '0;
            acc_q   <= '0;
            resp_q  <= '0;
            flags_q <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            resp_q  <= resp_d;
            flags_q <= flags_d;
        end
    end

endmodule

// File: tb/tb_alu_seq_flags.sv
// Directed self-checking bench for alu_seq_flags at WIDTH=8.
// Expectations for opcodes 14/15 follow whether ALU_DIV_EN is defined.
module tb_alu_seq_flags;

    localparam int W = 8;

    logic         iClk;
    logic         iRst_n;
    logic         iValid;
    logic         oReady;
    logic [4:0]   iOp;
    logic [W-1:0] iA;
    logic [W-1:0] iB;
    logic         oValid;
    logic [W-1:0] oResp;
    logic [5:0]   oFlags;

    int ntot = 0;
    int nbad = 0;

    alu_seq_flags #(.WIDTH(W)) dut (
        .iClk   (iClk),
        .iRst_n (iRst_n),
        .iValid (iValid),
        .oReady (oReady),
        .iOp    (iOp),
        .iA     (iA),
        .iB     (iB),
        .oValid (oValid),
        .oResp  (oResp),
        .oFlags (oFlags)
    );

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        ntot++;
        if (got !== exp) begin
            nbad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Called 1ns after a rising edge; returns 1ns after the accept edge.
    task automatic send(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        output int tries);
        logic rdy;
        iOp    = op;
        iA     = a;
        iB     = b;
        iValid = 1'b1;
        tries  = 0;
        while (1) begin
            rdy = oReady;
            @(posedge iClk);
            #1;
            if (rdy) break;
            tries++;
            if (tries > 64) begin
                check("send_timeout", oReady, 1);
                break;
            end
        end
        iValid = 1'b0;
        iOp    = 5'($urandom);
        iA     = W'($urandom);
        iB     = W'($urandom);
    endtask

    task automatic wait_valid(output int lat, output int nlow);
        lat  = 0;
        nlow = 0;
        while (1) begin
            @(posedge iClk);
            #1;
            lat++;
            if (oValid) break;
            if (!oReady) nlow++;
            if (lat >= 64) begin
                check("vld_timeout", oValid, 1);
                break;
            end
        end
    endtask

    task automatic run_op(input string tag, input logic [4:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] er, input logic [5:0] ef,
                          input int elat);
        int tries, lat, nlow;
        send(op, a, b, tries);
        wait_valid(lat, nlow);
        check({tag, "_lat"}, lat, elat);
        check({tag, "_res"}, oResp, er);
        check({tag, "_flg"}, oFlags, ef);
    endtask

    initial begin
        int tries, lat, nlow, seen;
        iRst_n = 1'b0;
        iValid = 1'b0;
        iOp    = '0;
        iA     = '0;
        iB     = '0;
        repeat (2) @(posedge iClk);
        #1;
        check("rst_ready", oReady, 1);
        check("rst_valid", oValid, 0);
        check("rst_resp", oResp, 0);
        check("rst_flags", oFlags, 0);
        iRst_n = 1'b1;
        @(posedge iClk);
        #1;

        // flags are {E,P,V,N,Z,C}
        run_op("add_ff_01", 5'd5, 8'hFF, 8'h01, 8'h00, 6'b000011, 1);
        run_op("sub_80_01", 5'd6, 8'h80, 8'h01, 8'h7F, 6'b011000, 1);
        @(posedge iClk);
        #1;
        check("pulse_low", oValid, 0);
        check("hold_resp", oResp, 8'h7F);
        check("hold_flg", oFlags, 6'b011000);
        run_op("sub_01_02", 5'd6, 8'h01, 8'h02, 8'hFF, 6'b000101, 1);
        run_op("dec_00", 5'd0, 8'h00, 8'h00, 8'hFF, 6'b000101, 1);
        run_op("inc_7f", 5'd7, 8'h7F, 8'h00, 8'h80, 6'b011100, 1);
        run_op("not_0f", 5'd3, 8'h0F, 8'h00, 8'hF0, 6'b000100, 1);
        run_op("xor", 5'd4, 8'hA5, 8'hFF, 8'h5A, 6'b000000, 1);
        run_op("shl_81", 5'd8, 8'h81, 8'h01, 8'h02, 6'b010001, 1);
        run_op("shr_81", 5'd9, 8'h81, 8'h01, 8'h40, 6'b010001, 1);
        run_op("sar_90", 5'd10, 8'h90, 8'h02, 8'hE4, 6'b000100, 1);
        run_op("ror_01", 5'd12, 8'h01, 8'h01, 8'h80, 6'b010100, 1);
        run_op("illegal20", 5'd20, 8'h12, 8'h34, 8'h00, 6'b100010, 1);

        // MUL with overflow, then ROL accepted in the DONE cycle
        send(5'd13, 8'h10, 8'h10, tries);
        check("mul_rdy_low", oReady, 0);
        wait_valid(lat, nlow);
        check("mul_lat", lat, 9);
        check("mul_rdy_cycles", nlow, 8);
        check("mul_res", oResp, 8'h00);
        check("mul_flg", oFlags, 6'b001010);
        check("mul_done_rdy", oReady, 1);
        send(5'd11, 8'h81, 8'h01, tries);
        check("b2b_tries", tries, 0);
        wait_valid(lat, nlow);
        check("rol_lat", lat, 1);
        check("rol_res", oResp, 8'h03);
        check("rol_flg", oFlags, 6'b000000);
        run_op("mul_0d_0b", 5'd13, 8'h0D, 8'h0B, 8'h8F, 6'b010100, 9);

`ifdef ALU_DIV_EN
        run_op("div_64_07", 5'd14, 8'h64, 8'h07, 8'h0E, 6'b010000, 9);
        run_op("mod_64_07", 5'd15, 8'h64, 8'h07, 8'h02, 6'b010000, 9);
        run_op("div_by0", 5'd14, 8'h64, 8'h00, 8'hFF, 6'b100100, 1);
        run_op("mod_by0", 5'd15, 8'h64, 8'h00, 8'h64, 6'b110000, 1);
`else
        run_op("div_off", 5'd14, 8'h64, 8'h07, 8'h00, 6'b100010, 1);
        run_op("mod_off", 5'd15, 8'h64, 8'h07, 8'h00, 6'b100010, 1);
        run_op("div_by0", 5'd14, 8'h64, 8'h00, 8'h00, 6'b100010, 1);
`endif

        // reset during BUSY cycle 4 of a multiply
        send(5'd13, 8'h03, 8'h05, tries);
        repeat (4) @(posedge iClk);
        #1;
        iRst_n = 1'b0;
        #1;
        check("mrst_valid", oValid, 0);
        check("mrst_resp", oResp, 0);
        check("mrst_flags", oFlags, 0);
        check("mrst_ready", oReady, 1);
        @(posedge iClk);
        #1;
        iRst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge iClk);
            #1;
            if (oValid) seen++;
        end
        check("mrst_no_vld", seen, 0);
        run_op("add_after_rst", 5'd5, 8'h02, 8'h03, 8'h05, 6'b000000, 1);

        $display("test done: total=%0d bad=%0d", ntot, nbad);
        $finish;
    end

endmodule
